goose_motion_ctrl: RTL and testbench

Frame-rate controller that sequences the goose sprite for the runner game: owns the game/pose state machine, the jump trajectory, slide pose, collision-to-game-over, and the score counter. Sits between the board buttons/VGA timing and the goose pixel-compare logic, which consumes `goose_y`/`goose_h` and returns a per-pixel `collide` flag.

---
 rtl/goose_pkg.sv | 68 ++++++
 rtl/goose_motion_ctrl_btn_sync_edge.sv | 35 +++
 rtl/goose_motion_ctrl.sv | 169 ++++++++++++++++
 tb/tb_goose_motion_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/goose_pkg.sv
// Shared types, geometry defaults and jump trajectory for the goose sprite controller.
package goose_pkg;

  localparam int unsigned Y_W     = 10;
  localparam int unsigned H_W     = 7;
  localparam int unsigned SCORE_W = 14;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned STEP_W  = 5;
  localparam int unsigned STATE_W = 3;

  localparam int unsigned GROUND_Y_DEF = 380;
  localparam int unsigned STAND_H_DEF  = 80;
  localparam int unsigned JUMP_H_DEF   = 40;
  localparam int unsigned SLIDE_H_DEF  = 60;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd16383;
  localparam logic [IDX_W-1:0]   JUMP_LAST = 5'd30;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_JUMP  = 3'd2,
    ST_SLIDE = 3'd3,
    ST_DEAD  = 3'd4
  } state_e;

  // Per-frame upward displacement; the 31 entries sum to zero so the goose lands on the ground.
  function automatic logic signed [STEP_W-1:0] jump_step(input logic [IDX_W-1:0] idx);
    logic signed [STEP_W-1:0] s;
    s = '0;
    case (idx)
      5'd0:  s = 5'sd15;
      5'd1:  s = 5'sd12;
      5'd2:  s = 5'sd9;
      5'd3:  s = 5'sd7;
      5'd4:  s = 5'sd5;
      5'd5:  s = 5'sd4;
      5'd6:  s = 5'sd3;
      5'd7:  s = 5'sd3;
      5'd8:  s = 5'sd2;
      5'd9:  s = 5'sd2;
      5'd10: s = 5'sd2;
      5'd11: s = 5'sd1;
      5'd12: s = 5'sd1;
      5'd13: s = 5'sd1;
      5'd14: s = 5'sd1;
      5'd15: s = 5'sd0;
      5'd16: s = -5'sd1;
      5'd17: s = -5'sd1;
      5'd18: s = -5'sd1;
      5'd19: s = -5'sd1;
      5'd20: s = -5'sd2;
      5'd21: s = -5'sd2;
      5'd22: s = -5'sd2;
      5'd23: s = -5'sd3;
      5'd24: s = -5'sd3;
      5'd25: s = -5'sd4;
      5'd26: s = -5'sd5;
      5'd27: s = -5'sd7;
      5'd28: s = -5'sd9;
      5'd29: s = -5'sd12;
      5'd30: s = -5'sd15;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/goose_motion_ctrl_btn_sync_edge.sv
// Two-flop button synchronizer with a registered rising-edge pulse.
module btn_sync_edge
  import goose_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_q;
  logic r_rise;

  // Synchronize the raw button and flag each synchronized 0->1 transition for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_q <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      r_meta   <= i_btn;
      r_sync   <= r_meta;
      r_sync_q <= r_sync;
      r_rise   <= r_sync & ~r_sync_q;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_rise;

endmodule

// File: rtl/goose_motion_ctrl.sv
// Frame-rate goose sequencer: game/pose FSM, jump trajectory, collision latch and score.
module goose_motion_ctrl
  import goose_pkg::*;
#(
  parameter int unsigned GROUND_Y = GROUND_Y_DEF,
  parameter int unsigned STAND_H  = STAND_H_DEF,
  parameter int unsigned JUMP_H   = JUMP_H_DEF,
  parameter int unsigned SLIDE_H  = SLIDE_H_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               btnL,
  input  logic               btnR,
  input  logic               collide,
  output logic [Y_W-1:0]     goose_y,
  output logic [H_W-1:0]     goose_h,
  output logic [STATE_W-1:0] state,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  localparam logic [Y_W-1:0] GROUND = Y_W'(GROUND_Y);
  localparam logic [H_W-1:0] H_STAND = H_W'(STAND_H);
  localparam logic [H_W-1:0] H_JUMP  = H_W'(JUMP_H);
  localparam logic [H_W-1:0] H_SLIDE = H_W'(SLIDE_H);

  state_e             r_state;
  logic [Y_W-1:0]     r_goose_y;
  logic [H_W-1:0]     r_goose_h;
  logic [SCORE_W-1:0] r_score;
  logic               r_game_over;
  logic [IDX_W-1:0]   r_idx;
  logic               r_jump_req;
  logic               r_hit;

  logic               w_jump_rise;
  logic               w_jump_level;
  logic               w_slide;
  logic               w_slide_rise;
  logic               w_unused_ok;
  logic               w_in_play;
  logic               w_hit;
  logic [SCORE_W-1:0] w_score_inc;
  logic signed [STEP_W-1:0] w_step;
  logic [Y_W-1:0]     w_step_ext;

  btn_sync_edge u_jump_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btnL),
    .o_level (w_jump_level),
    .o_rise  (w_jump_rise)
  );

  btn_sync_edge u_slide_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btnR),
    .o_level (w_slide),
    .o_rise  (w_slide_rise)
  );

  assign w_unused_ok = w_jump_level | w_slide_rise;

  // A collision arriving in the tick cycle itself must still count for that tick.
  assign w_in_play   = (r_state == ST_RUN) || (r_state == ST_JUMP) || (r_state == ST_SLIDE);
  assign w_hit       = r_hit | (collide & w_in_play);
  assign w_score_inc = (r_score == SCORE_MAX) ? r_score : r_score + SCORE_W'(1);
  assign w_step      = jump_step(r_idx);
  assign w_step_ext  = {{(Y_W-STEP_W){w_step[STEP_W-1]}}, w_step};

  // Game/pose FSM with registered sprite geometry, score and request/collision latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_goose_y   <= GROUND;
      r_goose_h   <= H_STAND;
      r_score     <= '0;
      r_game_over <= 1'b0;
      r_idx       <= '0;
      r_jump_req  <= 1'b0;
      r_hit       <= 1'b0;
    end else begin
      // Requests are consumed by every tick; presses made while airborne are dropped.
      r_jump_req <= (w_jump_rise & (r_state != ST_JUMP)) | (r_jump_req & ~frame_tick);

      if (w_in_play) begin
        r_hit <= w_hit;
      end else if (r_state == ST_IDLE) begin
        r_hit <= 1'b0;
      end

      if (frame_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (r_jump_req) begin
              r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            r_score <= w_score_inc;
            if (w_hit) begin
              r_state     <= ST_DEAD;
              r_game_over <= 1'b1;
            end else if (r_jump_req) begin
              r_state   <= ST_JUMP;
              r_idx     <= '0;
              r_goose_h <= H_JUMP;
            end else if (w_slide) begin
              r_state   <= ST_SLIDE;
              r_goose_h <= H_SLIDE;
            end
          end
          ST_JUMP: begin
            r_score <= w_score_inc;
            if (w_hit) begin
              r_state     <= ST_DEAD;
              r_game_over <= 1'b1;
            end else if (r_idx == JUMP_LAST) begin
              r_state   <= ST_RUN;
              r_goose_y <= GROUND;
              r_goose_h <= H_STAND;
              r_idx     <= '0;
            end else begin
              r_goose_y <= r_goose_y - w_step_ext;
              r_idx     <= r_idx + IDX_W'(1);
            end
          end
          ST_SLIDE: begin
            r_score <= w_score_inc;
            if (w_hit) begin
              r_state     <= ST_DEAD;
              r_game_over <= 1'b1;
            end else if (r_jump_req) begin
              r_state   <= ST_JUMP;
              r_idx     <= '0;
              r_goose_h <= H_JUMP;
            end else if (!w_slide) begin
              r_state   <= ST_RUN;
              r_goose_h <= H_STAND;
            end
          end
          ST_DEAD: begin
            if (r_jump_req) begin
              r_state     <= ST_IDLE;
              r_goose_y   <= GROUND;
              r_goose_h   <= H_STAND;
              r_score     <= '0;
              r_game_over <= 1'b0;
              r_idx       <= '0;
              r_hit       <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign goose_y   = r_goose_y;
  assign goose_h   = r_goose_h;
  assign state     = r_state;
  assign score     = r_score;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_goose_motion_ctrl.sv
// Self-checking bench: directed scenarios plus random play against a frame-level game model.
`timescale 1ns/1ps
module tb_goose_motion_ctrl;
  import goose_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        btnL;
  logic        btnR;
  logic        collide;
  logic [9:0]  goose_y;
  logic [6:0]  goose_h;
  logic [2:0]  state;
  logic [13:0] score;
  logic        game_over;

  int n_checks = 0;
  int n_errors = 0;

  int jt [31] = '{15, 12, 9, 7, 5, 4, 3, 3, 2, 2, 2, 1, 1, 1, 1, 0,
                  -1, -1, -1, -1, -2, -2, -2, -3, -3, -4, -5, -7, -9, -12, -15};

  state_e m_st;
  int     m_y, m_h, m_score, m_k;
  bit     m_over, m_req, m_hit, m_slide;

  goose_motion_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btnL       (btnL),
    .btnR       (btnR),
    .collide    (collide),
    .goose_y    (goose_y),
    .goose_h    (goose_h),
    .state      (state),
    .score      (score),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic int prefix(input int k);
    int s = 0;
    for (int i = 0; i < k; i++) s += jt[i];
    return s;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, int'(state), int'(m_st));
    chk({tag, ".y"}, int'(goose_y), m_y);
    chk({tag, ".h"}, int'(goose_h), m_h);
    chk({tag, ".score"}, int'(score), m_score);
    chk({tag, ".over"}, int'(game_over), int'(m_over));
  endtask

  task automatic model_reset();
    m_st = ST_IDLE; m_y = 380; m_h = 80; m_score = 0; m_k = 0;
    m_over = 0; m_req = 0; m_hit = 0; m_slide = 0;
  endtask

  function automatic bit in_play();
    return (m_st == ST_RUN) || (m_st == ST_JUMP) || (m_st == ST_SLIDE);
  endfunction

  task automatic model_tick(input bit col);
    if (in_play() && col) m_hit = 1;
    if (in_play() && m_score < 16383) m_score++;
    case (m_st)
      ST_IDLE: if (m_req) m_st = ST_RUN;
      ST_RUN: begin
        if (m_hit) begin m_st = ST_DEAD; m_over = 1; end
        else if (m_req) begin m_st = ST_JUMP; m_k = 0; m_h = 40; end
        else if (m_slide) begin m_st = ST_SLIDE; m_h = 60; end
      end
      ST_JUMP: begin
        if (m_hit) begin m_st = ST_DEAD; m_over = 1; end
        else begin
          m_k++;
          m_y = 380 - prefix(m_k);
          if (m_k == 31) begin m_st = ST_RUN; m_h = 80; m_y = 380; end
        end
      end
      ST_SLIDE: begin
        if (m_hit) begin m_st = ST_DEAD; m_over = 1; end
        else if (m_req) begin m_st = ST_JUMP; m_k = 0; m_h = 40; end
        else if (!m_slide) begin m_st = ST_RUN; m_h = 80; end
      end
      default: begin
        if (m_req) begin
          m_st = ST_IDLE; m_y = 380; m_h = 80; m_score = 0; m_over = 0; m_hit = 0;
        end
      end
    endcase
    m_req = 0;
  endtask

  task automatic tick(input string tag, input bit col);
    @(negedge clk);
    frame_tick = 1'b1;
    collide    = col;
    @(negedge clk);
    frame_tick = 1'b0;
    collide    = 1'b0;
    model_tick(col);
    check_all(tag);
  endtask

  task automatic press_jump();
    @(negedge clk);
    btnL = 1'b1;
    if (m_st != ST_JUMP) m_req = 1;
    repeat (4) @(negedge clk);
    btnL = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic set_slide(input bit v);
    @(negedge clk);
    btnR    = v;
    m_slide = v;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_collide();
    @(negedge clk);
    collide = 1'b1;
    if (in_play()) m_hit = 1;
    @(negedge clk);
    collide = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    btnL = 1'b0; btnR = 1'b0; collide = 1'b0; frame_tick = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; btnL = 1'b0; btnR = 1'b0; collide = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Start: first tick only leaves IDLE, next tick scores
    press_jump();
    tick("start", 1'b0);
    chk("start_score", int'(score), 0);
    tick("run1", 1'b0);
    chk("run1_score", int'(score), 1);

    // Full jump, with a press mid-air that must be ignored
    press_jump();
    tick("jump_enter", 1'b0);
    for (int i = 1; i <= 31; i++) begin
      if (i == 20) press_jump();
      tick("jump", 1'b0);
      if (i == 1)  chk("jump_first_y", int'(goose_y), 365);
      if (i == 15) chk("jump_apex_y", int'(goose_y), 312);
    end
    chk("jump_land_y", int'(goose_y), 380);
    chk("jump_land_h", int'(goose_h), 80);
    tick("after_jump", 1'b0);

    // Slide held for three ticks, released on the fourth
    set_slide(1'b1);
    repeat (3) tick("slide", 1'b0);
    set_slide(1'b0);
    tick("slide_rel", 1'b0);

    // Jump and slide on the same tick: jump wins
    press_jump();
    set_slide(1'b1);
    tick("jump_vs_slide", 1'b0);
    chk("jump_vs_slide_h", int'(goose_h), 40);
    set_slide(1'b0);

    // Collision pulse between ticks mid-jump, then freeze and restart
    repeat (10) tick("jump_pre_hit", 1'b0);
    pulse_collide();
    tick("hit", 1'b0);
    chk("hit_over", int'(game_over), 1);
    repeat (2) tick("dead_frozen", 1'b0);
    press_jump();
    tick("restart", 1'b0);

    // Collision coinciding with the tick
    press_jump();
    tick("run_again", 1'b0);
    tick("run_tick_hit", 1'b1);
    press_jump();
    tick("back_idle", 1'b0);

    // Asynchronous reset in the middle of a jump
    press_jump();
    tick("r_run", 1'b0);
    press_jump();
    tick("r_jump", 1'b0);
    repeat (20) tick("r_jump_air", 1'b0);
    do_reset();

    // Random play against the model
    for (int n = 0; n < 500; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2) press_jump();
      else if (r == 2) set_slide(1'(($urandom_range(0, 1))));
      else if (r == 3 && $urandom_range(0, 3) == 0) pulse_collide();
      else tick("rand", ($urandom_range(0, 19) == 0));
    end

    // Score saturation with a tick every cycle
    do_reset();
    press_jump();
    tick("sat_start", 1'b0);
    @(negedge clk);
    frame_tick = 1'b1;
    repeat (16400) begin
      @(negedge clk);
      model_tick(1'b0);
    end
    frame_tick = 1'b0;
    check_all("sat");
    chk("sat_score", int'(score), 16383);
    repeat (3) tick("sat_hold", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
